trigger_ctrl: RTL

Configuration and sequencing controller for the debug trigger-match datapath. Holds the per-trigger CSR state (tselect, tdata1/mcontrol, tdata2) and drives the comparator configuration. Resolves chained raw hits from the comparators into a single prioritized trigger event. Hands that event to the core over a req/ack handshake as a breakpoint exception or a debug-mode entry.

---
 rtl/trig_pkg.sv | 93 +++++++++
 rtl/trig_chain_resolve.sv | 46 ++++
 rtl/trigger_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared definitions for the debug trigger controller.
//   - CSR addresses for tselect / tdata1 / tdata2 / tinfo
//   - mcontrol bit positions, type constant, legalize/pack helpers
//   - match_e comparator mode, cstate_e / estate_e FSM states
package trig_pkg;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
    localparam logic [11:0] CSR_TINFO   = 12'h7A4;

    // tinfo: only mcontrol (type 2) is supported
    localparam logic [31:0] TINFO_VALUE   = 32'h0000_0004;
    localparam logic [3:0]  MCONTROL_TYPE = 4'd2;

    localparam int unsigned MC_TYPE_LSB   = 28;
    localparam int unsigned MC_DMODE      = 27;
    localparam int unsigned MC_HIT        = 20;
    localparam int unsigned MC_ACTION_LSB = 12;
    localparam int unsigned MC_CHAIN      = 11;
    localparam int unsigned MC_MATCH_LSB  = 7;
    localparam int unsigned MC_M          = 6;
    localparam int unsigned MC_U          = 3;
    localparam int unsigned MC_EXECUTE    = 2;
    localparam int unsigned MC_STORE      = 1;
    localparam int unsigned MC_LOAD       = 0;

    typedef enum logic [1:0] {
        EQ    = 2'b00,
        NAPOT = 2'b01,
        GE    = 2'b10,
        LT    = 2'b11
    } match_e;

    typedef enum logic {
        C_IDLE,
        C_RESP
    } cstate_e;

    typedef enum logic {
        E_IDLE,
        E_REQ
    } estate_e;

    // Only the legal state of mcontrol is stored; action is 0/1 so a single bit suffices.
    typedef struct packed {
        logic   dmode;
        logic   hit;
        logic   action;
        logic   chain;
        match_e match;
        logic   m;
        logic   u;
        logic   execute;
        logic   store;
        logic   load;
    } mcontrol_t;

    function automatic logic [31:0] mcontrol_pack(input mcontrol_t mc);
        logic [31:0] v;
        v = '0;
        v[MC_TYPE_LSB +: 4]  = MCONTROL_TYPE;
        v[MC_DMODE]          = mc.dmode;
        v[MC_HIT]            = mc.hit;
        v[MC_ACTION_LSB]     = mc.action;
        v[MC_CHAIN]          = mc.chain;
        v[MC_MATCH_LSB +: 2] = mc.match;
        v[MC_M]              = mc.m;
        v[MC_U]              = mc.u;
        v[MC_EXECUTE]        = mc.execute;
        v[MC_STORE]          = mc.store;
        v[MC_LOAD]           = mc.load;
        return v;
    endfunction

    // WARL legalization of a tdata1 write. dmode keeps its old value unless in debug mode.
    function automatic mcontrol_t mcontrol_legalize(input logic [31:0] w, input mcontrol_t old,
                                                    input logic debug_mode, input logic last);
        mcontrol_t mc;
        mc.dmode   = debug_mode ? w[MC_DMODE] : old.dmode;
        mc.hit     = w[MC_HIT];
        mc.action  = (w[MC_ACTION_LSB +: 4] == 4'd1);
        mc.chain   = last ? 1'b0 : w[MC_CHAIN];
        mc.match   = (w[MC_MATCH_LSB + 2 +: 2] == 2'b00) ? match_e'(w[MC_MATCH_LSB +: 2]) : EQ;
        mc.m       = w[MC_M];
        mc.u       = w[MC_U];
        mc.execute = w[MC_EXECUTE];
        mc.store   = w[MC_STORE];
        mc.load    = w[MC_LOAD];
        return mc;
    endfunction

endpackage

// File: rtl/trig_chain_resolve.sv
// trig_chain_resolve: combinational chain-group resolution.
//   hit_raw   - per-trigger comparator hit
//   hit_valid - an access is presented this cycle
//   chain     - per-trigger chain bit
//   fire      - some complete group hit
//   fire_idx  - terminating index of the lowest firing group
//   fire_mask - members of that group
module trig_chain_resolve
#(
    parameter  int NTRIG = 2,
    localparam int IW    = (NTRIG > 1) ? $clog2(NTRIG) : 1
) (
    input  logic [NTRIG-1:0] hit_raw,
    input  logic             hit_valid,
    input  logic [NTRIG-1:0] chain,
    output logic             fire,
    output logic [IW-1:0]    fire_idx,
    output logic [NTRIG-1:0] fire_mask
);

    // Walk upward accumulating the current group; a group closes at the first chain=0.
    // The first closing group that fully hit wins, giving lowest-terminator priority.
    always_comb begin
        logic             all_hit;
        logic [NTRIG-1:0] members;
        fire      = 1'b0;
        fire_idx  = '0;
        fire_mask = '0;
        all_hit   = 1'b1;
        members   = '0;
        for (int unsigned i = 0; i < NTRIG; i++) begin
            all_hit    = all_hit & hit_raw[i];
            members[i] = 1'b1;
            if (!chain[i]) begin
                if (hit_valid && all_hit && !fire) begin
                    fire      = 1'b1;
                    fire_idx  = IW'(i);
                    fire_mask = members;
                end
                all_hit = 1'b1;
                members = '0;
            end
        end
    end

endmodule

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: debug trigger CSR state, comparator configuration and event sequencing.
//   clock/reset          - core clock, async active-high reset
//   csr_*                - single-outstanding CSR access, csr_ready one cycle after csr_valid
//   debug_mode, priv_m   - core state used for dmode protection and trigger enables
//   trig_*               - per-trigger comparator configuration (registered, trig_en comb)
//   hit_raw, hit_valid   - comparator results for the current access
//   core_req/action/trig - pending trigger event, held until core_ack
module trigger_ctrl
    import trig_pkg::*;
#(
    parameter  int NTRIG = 2,
    parameter  int XLEN  = 32,
    localparam int IW    = (NTRIG > 1) ? $clog2(NTRIG) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  csr_valid,
    input  logic                  csr_write,
    input  logic [11:0]           csr_addr,
    input  logic [XLEN-1:0]       csr_wdata,
    output logic                  csr_ready,
    output logic [XLEN-1:0]       csr_rdata,
    input  logic                  debug_mode,
    input  logic                  priv_m,
    output logic [NTRIG*XLEN-1:0] trig_tdata2,
    output logic [NTRIG*2-1:0]    trig_match,
    output logic [NTRIG-1:0]      trig_exec,
    output logic [NTRIG-1:0]      trig_load,
    output logic [NTRIG-1:0]      trig_store,
    output logic [NTRIG-1:0]      trig_en,
    input  logic [NTRIG-1:0]      hit_raw,
    input  logic                  hit_valid,
    output logic                  core_req,
    output logic                  core_action,
    output logic [IW-1:0]         core_trig,
    input  logic                  core_ack
);

    cstate_e          cstate_q, cstate_d;
    estate_e          estate_q, estate_d;
    logic [11:0]      addr_q;
    logic [IW-1:0]    tselect_q;
    mcontrol_t        tdata1_q [NTRIG];
    logic [XLEN-1:0]  tdata2_q [NTRIG];
    logic             action_q;
    logic [IW-1:0]    trig_q;

    logic             csr_take;
    logic             sel_locked;
    logic             wr_tselect, wr_tdata1, wr_tdata2;
    mcontrol_t        tdata1_new;
    logic [NTRIG-1:0] chain_vec;
    logic             fire;
    logic [IW-1:0]    fire_idx;
    logic [NTRIG-1:0] fire_mask;
    logic             fire_accept;

    // ---------------- CSR write decode ----------------
    assign csr_take   = (cstate_q == C_IDLE) && csr_valid;
    assign sel_locked = tdata1_q[tselect_q].dmode && !debug_mode;
    assign wr_tselect = csr_take && csr_write && (csr_addr == CSR_TSELECT)
                        && (csr_wdata < XLEN'(NTRIG));
    assign wr_tdata1  = csr_take && csr_write && (csr_addr == CSR_TDATA1) && !sel_locked;
    assign wr_tdata2  = csr_take && csr_write && (csr_addr == CSR_TDATA2) && !sel_locked;
    assign tdata1_new = mcontrol_legalize(csr_wdata[31:0], tdata1_q[tselect_q], debug_mode,
                                          tselect_q == IW'(NTRIG - 1));

    // ---------------- trigger state registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tselect_q <= '0;
            for (int unsigned i = 0; i < NTRIG; i++) begin
                tdata1_q[i] <= '0;
                tdata2_q[i] <= '0;
            end
        end else begin
            if (wr_tselect) tselect_q <= IW'(csr_wdata);
            for (int unsigned i = 0; i < NTRIG; i++) begin
                if (wr_tdata1 && (tselect_q == IW'(i))) tdata1_q[i] <= tdata1_new;
                if (wr_tdata2 && (tselect_q == IW'(i))) tdata2_q[i] <= csr_wdata;
                // Ordered after the software write so a same-cycle hardware hit prevails.
                if (fire_accept && fire_mask[i]) tdata1_q[i].hit <= 1'b1;
            end
        end
    end

    // ---------------- configuration outputs ----------------
    always_comb begin
        trig_tdata2 = '0;
        trig_match  = '0;
        trig_exec   = '0;
        trig_load   = '0;
        trig_store  = '0;
        trig_en     = '0;
        chain_vec   = '0;
        for (int unsigned i = 0; i < NTRIG; i++) begin
            trig_tdata2[i*XLEN +: XLEN] = tdata2_q[i];
            trig_match[i*2 +: 2]        = tdata1_q[i].match;
            trig_exec[i]                = tdata1_q[i].execute;
            trig_load[i]                = tdata1_q[i].load;
            trig_store[i]               = tdata1_q[i].store;
            trig_en[i]                  = ((tdata1_q[i].m & priv_m) | (tdata1_q[i].u & ~priv_m))
                                          & ~debug_mode;
            chain_vec[i]                = tdata1_q[i].chain;
        end
    end

    // ---------------- CSR FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cstate_q <= C_IDLE;
            addr_q   <= '0;
        end else begin
            cstate_q <= cstate_d;
            if (csr_take) addr_q <= csr_addr;
        end
    end

    always_comb begin
        cstate_d = cstate_q;
        case (cstate_q)
            C_IDLE:  if (csr_valid) cstate_d = C_RESP;
            C_RESP:  cstate_d = C_IDLE;
            default: cstate_d = C_IDLE;
        endcase
    end

    always_comb begin
        csr_ready = 1'b0;
        csr_rdata = '0;
        if (cstate_q == C_RESP) begin
            csr_ready = 1'b1;
            case (addr_q)
                CSR_TSELECT: csr_rdata = XLEN'(tselect_q);
                CSR_TDATA1:  csr_rdata = XLEN'(mcontrol_pack(tdata1_q[tselect_q]));
                CSR_TDATA2:  csr_rdata = tdata2_q[tselect_q];
                CSR_TINFO:   csr_rdata = XLEN'(TINFO_VALUE);
                default:     csr_rdata = '0;
            endcase
        end
    end

    // ---------------- chain resolution ----------------
    trig_chain_resolve #(.NTRIG(NTRIG)) u_resolve (
        .hit_raw   (hit_raw),
        .hit_valid (hit_valid),
        .chain     (chain_vec),
        .fire      (fire),
        .fire_idx  (fire_idx),
        .fire_mask (fire_mask)
    );

    // ---------------- event FSM ----------------
    assign fire_accept = (estate_q == E_IDLE) && fire && !debug_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estate_q <= E_IDLE;
            action_q <= 1'b0;
            trig_q   <= '0;
        end else begin
            estate_q <= estate_d;
            if (fire_accept) begin
                action_q <= tdata1_q[fire_idx].action;
                trig_q   <= fire_idx;
            end
        end
    end

    always_comb begin
        estate_d = estate_q;
        case (estate_q)
            E_IDLE:  if (fire_accept) estate_d = E_REQ;
            E_REQ:   if (core_ack) estate_d = E_IDLE;
            default: estate_d = E_IDLE;
        endcase
    end

    always_comb begin
        core_req    = (estate_q == E_REQ);
        core_action = action_q;
        core_trig   = trig_q;
    end

endmodule
